relogio_bcd_param: RTL and testbench
====================================

Name: relogio_bcd_param

Overview:
Parametrised successor to the team's HH:MM:SS digital clock.
- Divides `clk` down to a 1 s tick and keeps time as BCD digits directly; no binary-to-digit conversion.
- Supports a preset load with seconds and input validation, a hold (pause), and a 12/24 h output mode.
- A display rotator shows seconds, minutes and hours in turn, each for a configurable dwell time.
- Feeds the board's 7-segment digit drivers.

Parameters:
- CLK_DIV, 10, `clk` cycles per 1 s tick; must be >= 2.
- DWELL_S, 15, 1 s ticks each display mode is shown; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_time  in  1  load preset on this cycle
- H_in1  in  2  preset hour tens (BCD)
- H_in0  in  4  preset hour units
- M_in1  in  4  preset minute tens
- M_in0  in  4  preset minute units
- S_in1  in  4  preset second tens
- S_in0  in  4  preset second units
- hold  in  1  pause time counting
- mode_12h  in  1  1 = 12 h output format
- tick_1s  out  1  one-cycle pulse per second
- ld_err  out  1  one-cycle pulse when a load is rejected
- H_out1  out  2  hour tens
- H_out0  out  4  hour units
- M_out1  out  4  minute tens
- M_out0  out  4  minute units
- S_out1  out  4  second tens
- S_out0  out  4  second units
- pm  out  1  PM flag; valid in 12 h mode, 0 in 24 h mode
- disp_mode  out  2  00 = seconds, 01 = minutes, 10 = hours
- alt_H_out1, alt_H_out0, alt_M_out1, alt_M_out0, alt_S_out1, alt_S_out0  out  2/4/4/4/4/4  rotated display digits

Behaviour:
- Clocking and reset: single clock `clk`. Reset is synchronous and active-high.
- Reset values:
  - divider = 0, time = 00:00:00.
  - tick_1s = 0, ld_err = 0, pm = 0.
  - disp_mode = 00, dwell counter = 0.
  - All alt_* outputs = 0.
  - Reset does not sample the preset inputs. Reset mid-count restarts the divider.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick_1s = 1 in the cycle the counter equals CLK_DIV-1.
  - The divider runs while hold = 1, but hold suppresses time increment.
- Time increment: on tick_1s with hold = 0 and ld_time = 0.
  - Seconds unit 9 -> 0 with carry into seconds tens.
  - Seconds tens 5 -> 0 with carry into minutes.
  - Minutes follow the same rule and carry into hours.
  - Hours roll 23 -> 00.
  - 23:59:59 -> 00:00:00 on a single tick.
  - Time outputs update the cycle after the tick.
- Load (ld_time = 1):
  - Has priority over the tick in the same cycle.
  - Valid preset: H <= 23, H_in0 <= 9, M_in1 <= 5, M_in0 <= 9, S_in1 <= 5, S_in0 <= 9.
  - Valid preset: time takes the preset on the next cycle, and the divider clears to 0, so the next tick arrives exactly CLK_DIV cycles later.
  - Invalid preset: time and divider are unchanged, and ld_err pulses for 1 cycle.
  - ld_time held high reloads every cycle.
- Output format: time is stored internally as 24 h; conversion is combinational on the outputs.
  - mode_12h = 1:
    - hour 00 -> 12, pm = 0.
    - 01..11 -> unchanged, pm = 0.
    - 12 -> 12, pm = 1.
    - 13..23 -> hour - 12, pm = 1.
  - mode_12h = 0: 24 h digits, pm = 0.
  - Toggling mode_12h never alters the stored time.
- Display FSM: states SHOW_S (00) -> SHOW_M (01) -> SHOW_H (10) -> SHOW_S.
  - The dwell counter increments on every tick_1s, including while hold = 1.
  - When the dwell counter = DWELL_S-1 on a tick, it clears and the FSM advances.
  - State 11 is unreachable; if entered, it recovers to SHOW_S on the next cycle.
- Alt outputs:
  - Registered every `clk` cycle, giving 1 cycle latency from the *_out outputs.
  - The selected pair mirrors the corresponding *_out pair; all other alt digits are 0.
  - In SHOW_H the hours pair follows the 12/24 h format.

Optional Feature:
ALARM_EN
- Macro defined:
  - Adds inputs al_set (1), A_H1 (2), A_H0 (4), A_M1 (4), A_M0 (4), al_clr (1), and output alarm (1).
  - al_set latches the alarm time; no validation is applied. Reset clears the alarm time to 00:00.
  - alarm sets on the cycle time becomes HH:MM:00 equal to the alarm time, through increment only; a load does not set it.
  - alarm stays set until al_clr or reset; al_clr wins over a simultaneous set.
- Macro undefined: these ports and their logic are absent.

Test Plan:
- CLK_DIV = 4, release reset: tick_1s pulses every 4 clk cycles; S_out0 steps 0 -> 1 -> 2 on consecutive ticks.
- Load 23:59:58, then 2 ticks: time reads 23:59:59, then 00:00:00 with all digits 0.
- ld_time with preset 24:00:00 or M_in1 = 6: ld_err = 1 for 1 cycle; time unchanged.
- Load 13:05:00 with mode_12h = 1: H_out = 01, pm = 1. Load 00:10:00: H_out = 12, pm = 0. Clearing mode_12h restores 13 and 00.
- DWELL_S = 2, CLK_DIV = 4: disp_mode reads 00, then 01 after 2 ticks, 10 after 4, 00 after 6. Alt non-selected digits are 0; the selected pair equals *_out delayed 1 cycle.
- hold = 1 for 5 ticks: time frozen and the dwell counter still advances. Reset asserted mid-second: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/relogio_bcd_param.sv
// HH:MM:SS BCD clock with preset load, hold, 12/24 h output and a rotating display selector.
// Optional alarm support is compiled in with `define ALARM_EN.
module relogio_bcd_param #(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned DWELL_S = 15
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ALARM_EN
  input  logic       al_set,
  input  logic [1:0] A_H1,
  input  logic [3:0] A_H0,
  input  logic [3:0] A_M1,
  input  logic [3:0] A_M0,
  input  logic       al_clr,
  output logic       alarm,
`endif
  input  logic       ld_time,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       hold,
  input  logic       mode_12h,
  output logic       tick_1s,
  output logic       ld_err,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0,
  output logic       pm,
  output logic [1:0] disp_mode,
  output logic [1:0] alt_H_out1,
  output logic [3:0] alt_H_out0,
  output logic [3:0] alt_M_out1,
  output logic [3:0] alt_M_out0,
  output logic [3:0] alt_S_out1,
  output logic [3:0] alt_S_out0
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned DWL_W = (DWELL_S > 1) ? $clog2(DWELL_S) : 1;

  typedef enum logic [1:0] {
    SHOW_S = 2'b00,
    SHOW_M = 2'b01,
    SHOW_H = 2'b10
  } disp_state_t;

  logic [DIV_W-1:0] r_div;
  logic [DWL_W-1:0] r_dwell;
  disp_state_t      r_state;
  disp_state_t      w_state_nxt;
  logic [1:0]       r_h1;
  logic [3:0]       r_h0, r_m1, r_m0, r_s1, r_s0;
  logic [1:0]       w_h1_n;
  logic [3:0]       w_h0_n, w_m1_n, w_m0_n, w_s1_n, w_s0_n;
  logic             r_ld_err;
  logic [1:0]       r_alt_h1;
  logic [3:0]       r_alt_h0, r_alt_m1, r_alt_m0, r_alt_s1, r_alt_s0;
  logic             w_tick;
  logic             w_ld_ok;
  logic             w_inc;
  logic             w_dwell_wrap;
  logic [4:0]       w_hbin;
  logic [4:0]       w_h12;

  assign w_tick  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_ld_ok = ((H_in1 < 2'd2 && H_in0 <= 4'd9) || (H_in1 == 2'd2 && H_in0 <= 4'd3)) &&
                   (M_in1 <= 4'd5) && (M_in0 <= 4'd9) && (S_in1 <= 4'd5) && (S_in0 <= 4'd9);
  assign w_inc   = w_tick && !hold && !ld_time;

  // 1 s divider; a successful load realigns the second boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if ((ld_time && w_ld_ok) || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // BCD ripple increment with per-digit carry
  always_comb begin
    w_s0_n = r_s0;
    w_s1_n = r_s1;
    w_m0_n = r_m0;
    w_m1_n = r_m1;
    w_h0_n = r_h0;
    w_h1_n = r_h1;
    if (r_s0 != 4'd9) begin
      w_s0_n = r_s0 + 4'd1;
    end else begin
      w_s0_n = '0;
      if (r_s1 != 4'd5) begin
        w_s1_n = r_s1 + 4'd1;
      end else begin
        w_s1_n = '0;
        if (r_m0 != 4'd9) begin
          w_m0_n = r_m0 + 4'd1;
        end else begin
          w_m0_n = '0;
          if (r_m1 != 4'd5) begin
            w_m1_n = r_m1 + 4'd1;
          end else begin
            w_m1_n = '0;
            if (r_h1 == 2'd2 && r_h0 == 4'd3) begin
              w_h1_n = '0;
              w_h0_n = '0;
            end else if (r_h0 == 4'd9) begin
              w_h0_n = '0;
              w_h1_n = r_h1 + 2'd1;
            end else begin
              w_h0_n = r_h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h1 <= '0;
      r_h0 <= '0;
      r_m1 <= '0;
      r_m0 <= '0;
      r_s1 <= '0;
      r_s0 <= '0;
    end else if (ld_time) begin
      if (w_ld_ok) begin
        r_h1 <= H_in1;
        r_h0 <= H_in0;
        r_m1 <= M_in1;
        r_m0 <= M_in0;
        r_s1 <= S_in1;
        r_s0 <= S_in0;
      end
    end else if (w_inc) begin
      r_h1 <= w_h1_n;
      r_h0 <= w_h0_n;
      r_m1 <= w_m1_n;
      r_m0 <= w_m0_n;
      r_s1 <= w_s1_n;
      r_s0 <= w_s0_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= ld_time && !w_ld_ok;
    end
  end

  // 12 h view is derived from the 24 h store and never written back
  always_comb begin
    w_hbin = 5'(r_h1) * 5'd10 + 5'(r_h0);
    if (w_hbin == 5'd0) begin
      w_h12 = 5'd12;
    end else if (w_hbin > 5'd12) begin
      w_h12 = w_hbin - 5'd12;
    end else begin
      w_h12 = w_hbin;
    end
    H_out1 = r_h1;
    H_out0 = r_h0;
    pm     = 1'b0;
    if (mode_12h) begin
      pm     = (w_hbin >= 5'd12);
      H_out1 = (w_h12 >= 5'd10) ? 2'd1 : 2'd0;
      H_out0 = (w_h12 >= 5'd10) ? 4'(w_h12 - 5'd10) : 4'(w_h12);
    end
  end

  assign M_out1  = r_m1;
  assign M_out0  = r_m0;
  assign S_out1  = r_s1;
  assign S_out0  = r_s0;
  assign tick_1s = w_tick;
  assign ld_err  = r_ld_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dwell <= '0;
    end else if (w_tick) begin
      r_dwell <= w_dwell_wrap ? '0 : r_dwell + DWL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SHOW_S;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_wrap = w_tick && (r_dwell == DWL_W'(DWELL_S - 1));
    case (r_state)
      SHOW_S:  if (w_dwell_wrap) w_state_nxt = SHOW_M;
      SHOW_M:  if (w_dwell_wrap) w_state_nxt = SHOW_H;
      SHOW_H:  if (w_dwell_wrap) w_state_nxt = SHOW_S;
      default: w_state_nxt = SHOW_S;
    endcase
  end

  assign disp_mode = r_state;

  // Rotated digits: only the pair selected by the current state is passed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alt_h1 <= '0;
      r_alt_h0 <= '0;
      r_alt_m1 <= '0;
      r_alt_m0 <= '0;
      r_alt_s1 <= '0;
      r_alt_s0 <= '0;
    end else begin
      r_alt_s1 <= (r_state == SHOW_S) ? S_out1 : '0;
      r_alt_s0 <= (r_state == SHOW_S) ? S_out0 : '0;
      r_alt_m1 <= (r_state == SHOW_M) ? M_out1 : '0;
      r_alt_m0 <= (r_state == SHOW_M) ? M_out0 : '0;
      r_alt_h1 <= (r_state == SHOW_H) ? H_out1 : '0;
      r_alt_h0 <= (r_state == SHOW_H) ? H_out0 : '0;
    end
  end

  assign alt_H_out1 = r_alt_h1;
  assign alt_H_out0 = r_alt_h0;
  assign alt_M_out1 = r_alt_m1;
  assign alt_M_out0 = r_alt_m0;
  assign alt_S_out1 = r_alt_s1;
  assign alt_S_out0 = r_alt_s0;

`ifdef ALARM_EN
  logic [1:0] r_a_h1;
  logic [3:0] r_a_h0, r_a_m1, r_a_m0;
  logic       r_alarm;
  logic       w_al_hit;

  // Only a counted rollover into HH:MM:00 can fire the alarm
  assign w_al_hit = w_inc && (w_s1_n == 4'd0) && (w_s0_n == 4'd0) &&
                    (w_h1_n == r_a_h1) && (w_h0_n == r_a_h0) &&
                    (w_m1_n == r_a_m1) && (w_m0_n == r_a_m0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_h1  <= '0;
      r_a_h0  <= '0;
      r_a_m1  <= '0;
      r_a_m0  <= '0;
      r_alarm <= 1'b0;
    end else begin
      if (al_set) begin
        r_a_h1 <= A_H1;
        r_a_h0 <= A_H0;
        r_a_m1 <= A_M1;
        r_a_m0 <= A_M0;
      end
      if (al_clr) begin
        r_alarm <= 1'b0;
      end else if (w_al_hit) begin
        r_alarm <= 1'b1;
      end
    end
  end

  assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_relogio_bcd_param.sv
// Directed self-checking bench for relogio_bcd_param with CLK_DIV = 4 and DWELL_S = 2.
module tb_relogio_bcd_param;

  logic       clk;
  logic       reset;
  logic       ld_time;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
  logic       hold;
  logic       mode_12h;
  logic       tick_1s;
  logic       ld_err;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
  logic       pm;
  logic [1:0] disp_mode;
  logic [1:0] alt_H_out1;
  logic [3:0] alt_H_out0, alt_M_out1, alt_M_out0, alt_S_out1, alt_S_out0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [21:0] w_time;
  logic [21:0] w_alt;
  logic [6:0]  w_hfmt;
  assign w_time = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  assign w_alt  = {alt_H_out1, alt_H_out0, alt_M_out1, alt_M_out0, alt_S_out1, alt_S_out0};
  assign w_hfmt = {H_out1, H_out0, pm};

  relogio_bcd_param #(.CLK_DIV(4), .DWELL_S(2)) dut (
    .clk(clk), .reset(reset), .ld_time(ld_time),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0), .S_in1(S_in1), .S_in0(S_in0),
    .hold(hold), .mode_12h(mode_12h), .tick_1s(tick_1s), .ld_err(ld_err),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0), .pm(pm), .disp_mode(disp_mode),
    .alt_H_out1(alt_H_out1), .alt_H_out0(alt_H_out0), .alt_M_out1(alt_M_out1),
    .alt_M_out0(alt_M_out0), .alt_S_out1(alt_S_out1), .alt_S_out0(alt_S_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] mk(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                                     input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                      input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0; S_in1 = s1; S_in0 = s0;
    ld_time = 1'b1;
    cyc(1);
    ld_time = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++; if (w_time !== 22'd0) begin n_fail++; $display("FAIL %s time got=%h exp=0", tag, w_time); end
    n_checks++; if (tick_1s !== 1'b0) begin n_fail++; $display("FAIL %s tick got=%b exp=0", tag, tick_1s); end
    n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL %s ld_err got=%b exp=0", tag, ld_err); end
    n_checks++; if (pm !== 1'b0) begin n_fail++; $display("FAIL %s pm got=%b exp=0", tag, pm); end
    n_checks++; if (disp_mode !== 2'd0) begin n_fail++; $display("FAIL %s disp got=%0d exp=0", tag, disp_mode); end
    n_checks++; if (w_alt !== 22'd0) begin n_fail++; $display("FAIL %s alt got=%h exp=0", tag, w_alt); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_tick;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      n_checks++;
      if (tick_1s !== (i % 4 == 3)) begin n_fail++; $display("FAIL tick c=%0d got=%b", i, tick_1s); end
      n_checks++;
      if (S_out0 !== 4'(i / 4)) begin n_fail++; $display("FAIL s0 c=%0d got=%0d exp=%0d", i, S_out0, i / 4); end
    end
  endtask

  task automatic test_load_rollover;
    do_reset();
    load(2'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
    n_checks++;
    if (w_time !== mk(2, 3, 5, 9, 5, 8)) begin n_fail++; $display("FAIL load got=%h", w_time); end
    for (int j = 1; j <= 8; j++) begin
      cyc(1);
      n_checks++;
      if (tick_1s !== (j % 4 == 3)) begin n_fail++; $display("FAIL ld_tick c=%0d got=%b", j, tick_1s); end
      if (j == 4) begin
        n_checks++;
        if (w_time !== mk(2, 3, 5, 9, 5, 9)) begin n_fail++; $display("FAIL t235959 got=%h", w_time); end
      end
      if (j == 8) begin
        n_checks++;
        if (w_time !== 22'd0) begin n_fail++; $display("FAIL rollover got=%h exp=0", w_time); end
      end
    end
    H_in1 = 2'd1; H_in0 = 4'd0; M_in1 = 4'd2; M_in0 = 4'd0; S_in1 = 4'd3; S_in0 = 4'd0;
    ld_time = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      n_checks++;
      if (w_time !== mk(1, 0, 2, 0, 3, 0) || tick_1s !== 1'b0) begin
        n_fail++; $display("FAIL held_load c=%0d time=%h tick=%b", k, w_time, tick_1s);
      end
    end
    ld_time = 1'b0;
  endtask

  task automatic test_invalid;
    do_reset();
    load(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    H_in1 = 2'd2; H_in0 = 4'd4; M_in1 = 4'd0; M_in0 = 4'd0; S_in1 = 4'd0; S_in0 = 4'd0;
    ld_time = 1'b1;
    cyc(1);
    ld_time = 1'b0;
    n_checks++; if (ld_err !== 1'b1) begin n_fail++; $display("FAIL err24 got=%b exp=1", ld_err); end
    n_checks++; if (w_time !== mk(1, 2, 3, 4, 5, 6)) begin n_fail++; $display("FAIL err24_time got=%h", w_time); end
    cyc(1);
    n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL err24_pulse got=%b exp=0", ld_err); end
    H_in1 = 2'd1; H_in0 = 4'd0; M_in1 = 4'd6; M_in0 = 4'd0;
    ld_time = 1'b1;
    cyc(1);
    ld_time = 1'b0;
    n_checks++; if (ld_err !== 1'b1) begin n_fail++; $display("FAIL errM6 got=%b exp=1", ld_err); end
    n_checks++; if (w_time !== mk(1, 2, 3, 4, 5, 6)) begin n_fail++; $display("FAIL errM6_time got=%h", w_time); end
    cyc(1);
    n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL errM6_pulse got=%b exp=0", ld_err); end
  endtask

  task automatic test_12h;
    do_reset();
    mode_12h = 1'b1;
    load(2'd1, 4'd3, 4'd0, 4'd5, 4'd0, 4'd0);
    n_checks++; if (w_hfmt !== {2'd0, 4'd1, 1'b1}) begin n_fail++; $display("FAIL h13_12h got=%h", w_hfmt); end
    n_checks++; if ({M_out1, M_out0} !== 8'h05) begin n_fail++; $display("FAIL min05 got=%h", {M_out1, M_out0}); end
    load(2'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);
    n_checks++; if (w_hfmt !== {2'd1, 4'd2, 1'b0}) begin n_fail++; $display("FAIL h00_12h got=%h", w_hfmt); end
    mode_12h = 1'b0;
    #1;
    n_checks++; if (w_hfmt !== {2'd0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL h00_24h got=%h", w_hfmt); end
    mode_12h = 1'b1;
    load(2'd1, 4'd3, 4'd0, 4'd5, 4'd0, 4'd0);
    mode_12h = 1'b0;
    #1;
    n_checks++; if (w_hfmt !== {2'd1, 4'd3, 1'b0}) begin n_fail++; $display("FAIL h13_24h got=%h", w_hfmt); end
    mode_12h = 1'b1;
    load(2'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0);
    n_checks++; if (w_hfmt !== {2'd1, 4'd2, 1'b1}) begin n_fail++; $display("FAIL h12_12h got=%h", w_hfmt); end
    mode_12h = 1'b0;
  endtask

  task automatic test_disp;
    int pd;
    logic [21:0] ea;
    do_reset();
    mode_12h = 1'b1;
    load(2'd1, 4'd3, 4'd3, 4'd4, 4'd5, 4'd0);
    for (int j = 1; j <= 26; j++) begin
      cyc(1);
      n_checks++;
      if (disp_mode !== 2'((j / 8) % 3)) begin
        n_fail++; $display("FAIL disp c=%0d got=%0d exp=%0d", j, disp_mode, (j / 8) % 3);
      end
      pd = ((j - 1) / 8) % 3;
      if (pd == 0)      ea = mk(0, 0, 0, 0, 5, 4'((j - 1) / 4));
      else if (pd == 1) ea = mk(0, 0, 3, 4, 0, 0);
      else              ea = mk(0, 1, 0, 0, 0, 0);
      n_checks++;
      if (w_alt !== ea) begin n_fail++; $display("FAIL alt c=%0d got=%h exp=%h", j, w_alt, ea); end
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_hold;
    do_reset();
    load(2'd0, 4'd8, 4'd1, 4'd5, 4'd3, 4'd0);
    hold = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      cyc(1);
      n_checks++;
      if (tick_1s !== (j % 4 == 3)) begin n_fail++; $display("FAIL hold_tick c=%0d got=%b", j, tick_1s); end
    end
    n_checks++; if (w_time !== mk(0, 8, 1, 5, 3, 0)) begin n_fail++; $display("FAIL hold_time got=%h", w_time); end
    n_checks++; if (disp_mode !== 2'd2) begin n_fail++; $display("FAIL hold_dwell got=%0d exp=2", disp_mode); end
    hold = 1'b0;
    cyc(4);
    n_checks++; if (w_time !== mk(0, 8, 1, 5, 3, 1)) begin n_fail++; $display("FAIL unhold got=%h", w_time); end
  endtask

  task automatic test_reset_mid;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check_all_zero("mid_reset");
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      n_checks++;
      if (tick_1s !== (k == 3)) begin n_fail++; $display("FAIL restart_tick c=%0d got=%b", k, tick_1s); end
    end
  endtask

  initial begin
    reset = 1'b1; ld_time = 1'b0; hold = 1'b0; mode_12h = 1'b0;
    H_in1 = '0; H_in0 = '0; M_in1 = '0; M_in0 = '0; S_in1 = '0; S_in0 = '0;
    test_reset();
    test_tick();
    test_load_rollover();
    test_invalid();
    test_12h();
    test_disp();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
